// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAP,
    ST_MRET,
    ST_REDIR
  } state_e;

  localparam logic [3:0] CAUSE_MEI      = 4'd11;
  localparam logic [3:0] CAUSE_MSI      = 4'd3;
  localparam logic [3:0] CAUSE_MTI      = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M  = 4'd11;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, cleared by async reset.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: turns exceptions, interrupts and MRET into CSR hardware writes and a fetch redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        int_boundary,
  input  logic [31:0] int_pc,
  input  logic        irq_ext,
  input  logic        irq_tmr,
  input  logic        irq_sw,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic        mie_msie,
  input  logic [29:0] mtvec_base,
  input  logic [1:0]  mtvec_mode,
  input  logic [31:0] mepc_value,
  output logic        mepc_wen,
  output logic [31:0] mepc_wdata,
  output logic        mcause_int_wen,
  output logic        mcause_int,
  output logic        mcause_code_wen,
  output logic [30:0] mcause_code,
  output logic        mtval_wen,
  output logic [31:0] mtval_wdata,
  output logic        mpie_wen,
  output logic        mpie_wdata,
  output logic        mie_wen,
  output logic        mie_wdata,
  output logic        mip_meip,
  output logic        mip_mtip,
  output logic        mip_msip,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  state_e      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic        isInt_q, isInt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] target_q, target_d;
  logic [2:0]  pending;
  logic [31:0] vecBase;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (.clk(clk), .rst_n(rst_n), .d_i(irq_ext), .q_o(mip_meip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_tmr (.clk(clk), .rst_n(rst_n), .d_i(irq_tmr), .q_o(mip_mtip));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw  (.clk(clk), .rst_n(rst_n), .d_i(irq_sw),  .q_o(mip_msip));

  // Ordered so that bit 2 wins, then bit 1, then bit 0: MEI > MSI > MTI.
  assign pending = {mip_meip & mie_meie, mip_msip & mie_msie, mip_mtip & mie_mtie};
  assign vecBase = {mtvec_base, 2'b00};

  always_comb begin
    state_d         = state_q;
    code_d          = code_q;
    isInt_d         = isInt_q;
    epc_d           = epc_q;
    tval_d          = tval_q;
    target_d        = target_q;
    mepc_wen        = 1'b0;
    mepc_wdata      = '0;
    mcause_int_wen  = 1'b0;
    mcause_int      = 1'b0;
    mcause_code_wen = 1'b0;
    mcause_code     = '0;
    mtval_wen       = 1'b0;
    mtval_wdata     = '0;
    mpie_wen        = 1'b0;
    mpie_wdata      = 1'b0;
    mie_wen         = 1'b0;
    mie_wdata       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          code_d  = exc_code;
          epc_d   = exc_pc;
          tval_d  = exc_tval;
          isInt_d = 1'b0;
          state_d = ST_TRAP;
        end else if (int_boundary && mstatus_mie && (pending != 3'b000)) begin
          if (pending[2])      code_d = CAUSE_MEI;
          else if (pending[1]) code_d = CAUSE_MSI;
          else                 code_d = CAUSE_MTI;
          epc_d   = int_pc;
          tval_d  = '0;
          isInt_d = 1'b1;
          state_d = ST_TRAP;
        end else if (mret_valid) begin
          state_d = ST_MRET;
        end
      end
      ST_TRAP: begin
        mepc_wen        = 1'b1;
        mepc_wdata      = epc_q;
        mcause_int_wen  = 1'b1;
        mcause_int      = isInt_q;
        mcause_code_wen = 1'b1;
        mcause_code     = {27'b0, code_q};
        mtval_wen       = 1'b1;
        mtval_wdata     = tval_q;
        mpie_wen        = 1'b1;
        mpie_wdata      = mstatus_mie;
        mie_wen         = 1'b1;
        mie_wdata       = 1'b0;
        // Modes 2 and 3 fall back to direct.
        if ((mtvec_mode == MTVEC_VECTORED) && isInt_q)
          target_d = vecBase + {26'b0, code_q, 2'b00};
        else
          target_d = vecBase;
        state_d = ST_REDIR;
      end
      ST_MRET: begin
        mpie_wen   = 1'b1;
        mpie_wdata = 1'b1;
        mie_wen    = 1'b1;
        mie_wdata  = mstatus_mpie;
        target_d   = mepc_value;
        state_d    = ST_REDIR;
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= '0;
      isInt_q  <= 1'b0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      isInt_q  <= isInt_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
    end
  end

  assign stall = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl with hand-computed expectations.
module tb_trap_ctrl;

  logic        clk, rst_n;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc, exc_tval;
  logic        mret_valid, int_boundary;
  logic [31:0] int_pc;
  logic        irq_ext, irq_tmr, irq_sw;
  logic        mstatus_mie, mstatus_mpie;
  logic        mie_meie, mie_mtie, mie_msie;
  logic [29:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic [31:0] mepc_value;
  logic        mepc_wen;
  logic [31:0] mepc_wdata;
  logic        mcause_int_wen, mcause_int, mcause_code_wen;
  logic [30:0] mcause_code;
  logic        mtval_wen;
  logic [31:0] mtval_wdata;
  logic        mpie_wen, mpie_wdata, mie_wen, mie_wdata;
  logic        mip_meip, mip_mtip, mip_msip;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int total = 0;
  int bad   = 0;

  trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .int_boundary(int_boundary), .int_pc(int_pc),
    .irq_ext(irq_ext), .irq_tmr(irq_tmr), .irq_sw(irq_sw),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
    .mie_meie(mie_meie), .mie_mtie(mie_mtie), .mie_msie(mie_msie),
    .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_value(mepc_value),
    .mepc_wen(mepc_wen), .mepc_wdata(mepc_wdata),
    .mcause_int_wen(mcause_int_wen), .mcause_int(mcause_int),
    .mcause_code_wen(mcause_code_wen), .mcause_code(mcause_code),
    .mtval_wen(mtval_wen), .mtval_wdata(mtval_wdata),
    .mpie_wen(mpie_wen), .mpie_wdata(mpie_wdata), .mie_wen(mie_wen), .mie_wdata(mie_wdata),
    .mip_meip(mip_meip), .mip_mtip(mip_mtip), .mip_msip(mip_msip),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWensLow(input string tag);
    checkOutput({tag, ".wens"},
                {26'b0, mepc_wen, mcause_int_wen, mcause_code_wen, mtval_wen, mpie_wen, mie_wen},
                32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    mret_valid = 1'b0; int_boundary = 1'b1; int_pc = 32'h444;
    irq_ext = 1'b0; irq_tmr = 1'b0; irq_sw = 1'b0;
    mstatus_mie = 1'b1; mstatus_mpie = 1'b0;
    mie_meie = 1'b0; mie_mtie = 1'b0; mie_msie = 1'b0;
    mtvec_base = 30'h40; mtvec_mode = 2'd0; mepc_value = '0;
    redirect_ready = 1'b0;

    #12;
    checkOutput("reset.stall", {31'b0, stall}, 32'h0);
    checkOutput("reset.redir", {31'b0, redirect_valid}, 32'h0);
    checkOutput("reset.mip", {29'b0, mip_meip, mip_mtip, mip_msip}, 32'h0);
    checkWensLow("reset");
    #10 rst_n = 1'b1;
    applyStimulus();

    // 1: direct-mode exception
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h80; exc_tval = 32'hDEAD;
    applyStimulus();
    exc_valid = 1'b0;
    checkOutput("t1.mepc_wen", {31'b0, mepc_wen}, 32'h1);
    checkOutput("t1.mepc", mepc_wdata, 32'h80);
    checkOutput("t1.mcause", {mcause_int, mcause_code}, 32'h2);
    checkOutput("t1.mtval", mtval_wdata, 32'hDEAD);
    checkOutput("t1.mie_mpie", {30'b0, mie_wen, mie_wdata}, 32'h2);
    checkOutput("t1.mpie", {30'b0, mpie_wen, mpie_wdata}, 32'h3);
    checkOutput("t1.redir_early", {31'b0, redirect_valid}, 32'h0);
    applyStimulus();
    checkOutput("t1.redir_valid", {31'b0, redirect_valid}, 32'h1);
    checkOutput("t1.redir_pc", redirect_pc, 32'h100);
    checkWensLow("t1.redir");
    redirect_ready = 1'b1;
    applyStimulus();
    redirect_ready = 1'b0;
    checkOutput("t1.idle_stall", {31'b0, stall}, 32'h0);

    // 2: vectored external interrupt, two-flop synchroniser
    mtvec_mode = 2'd1; mie_meie = 1'b1; irq_ext = 1'b1;
    applyStimulus();
    checkOutput("t2.mip_early", {31'b0, mip_meip}, 32'h0);
    applyStimulus();
    checkOutput("t2.mip", {31'b0, mip_meip}, 32'h1);
    checkOutput("t2.stall_pre", {31'b0, stall}, 32'h0);
    applyStimulus();
    checkOutput("t2.mcause", {mcause_int, mcause_code}, 32'h8000000B);
    checkOutput("t2.mepc", mepc_wdata, 32'h444);
    checkOutput("t2.mtval", mtval_wdata, 32'h0);
    mstatus_mie = 1'b0;
    applyStimulus();
    checkOutput("t2.redir_pc", redirect_pc, 32'h12C);
    irq_ext = 1'b0; redirect_ready = 1'b1;
    applyStimulus();
    redirect_ready = 1'b0;
    applyStimulus();
    applyStimulus();

    // 3: all three lines together; MEI wins, then MIE=0 blocks the rest
    mstatus_mie = 1'b1; mie_msie = 1'b1; mie_mtie = 1'b1;
    irq_ext = 1'b1; irq_sw = 1'b1; irq_tmr = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t3.mcause", {mcause_int, mcause_code}, 32'h8000000B);
    checkOutput("t3.mie", {30'b0, mie_wen, mie_wdata}, 32'h2);
    mstatus_mie = 1'b0;
    applyStimulus();
    redirect_ready = 1'b1;
    applyStimulus();
    redirect_ready = 1'b0; irq_ext = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("t3.masked%0d", i), {30'b0, stall, mip_msip}, 32'h1);
    end
    irq_sw = 1'b0; irq_tmr = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    // 4: MRET with a slow fetch
    mepc_value = 32'h200; mstatus_mpie = 1'b1; mret_valid = 1'b1;
    applyStimulus();
    mret_valid = 1'b0;
    checkOutput("t4.mie", {30'b0, mie_wen, mie_wdata}, 32'h3);
    checkOutput("t4.mpie", {30'b0, mpie_wen, mpie_wdata}, 32'h3);
    checkOutput("t4.mepc_wen", {31'b0, mepc_wen}, 32'h0);
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4.hold%0d", i), {29'b0, stall, redirect_valid, 1'b0}, 32'h6);
      checkOutput($sformatf("t4.pc%0d", i), redirect_pc, 32'h200);
      applyStimulus();
    end
    redirect_ready = 1'b1;
    applyStimulus();
    redirect_ready = 1'b0;
    checkOutput("t4.idle", {31'b0, stall}, 32'h0);

    // 5: exception beats MRET; exceptions in REDIR are dropped
    mstatus_mie = 1'b1; mtvec_mode = 2'd0;
    exc_valid = 1'b1; mret_valid = 1'b1; exc_code = 4'd11; exc_pc = 32'h90; exc_tval = 32'h0;
    applyStimulus();
    exc_valid = 1'b0; mret_valid = 1'b0;
    checkOutput("t5.mepc", mepc_wdata, 32'h90);
    checkOutput("t5.mcause", {mcause_int, mcause_code}, 32'hB);
    checkOutput("t5.mpie", {30'b0, mpie_wen, mpie_wdata}, 32'h3);
    applyStimulus();
    checkOutput("t5.redir_pc", redirect_pc, 32'h100);
    exc_valid = 1'b1;
    applyStimulus();
    checkOutput("t5.still_redir", {31'b0, redirect_valid}, 32'h1);
    checkWensLow("t5.ignored");
    exc_valid = 1'b0; redirect_ready = 1'b1;
    applyStimulus();
    redirect_ready = 1'b0;
    checkOutput("t5.idle", {31'b0, stall}, 32'h0);
    checkWensLow("t5.idle");

    // 6: reset arriving in REDIR
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'hA0;
    applyStimulus();
    exc_valid = 1'b0;
    applyStimulus();
    checkOutput("t6.redir", {31'b0, redirect_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6.async", {30'b0, stall, redirect_valid}, 32'h0);
    #3 rst_n = 1'b1;
    applyStimulus();
    checkOutput("t6.after", {30'b0, stall, redirect_valid}, 32'h0);
    checkWensLow("t6.after");
    applyStimulus();
    checkWensLow("t6.after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
